calc_key_entry: RTL
===================

// Module: calc_key_entry
// PURPOSE
//   Consumes the 5-bit {valid,code} key stream from the keypad scanner on the same clock.
//   Turns key presses into two decimal operands and an operator, then issues a valid/ready
//   request to the arithmetic unit. Latches the returned result for display and for chaining.
//   Sits between the keypad scanner and the ALU/display path.
// PARAMETERS
//   WIDTH       16  operand/result width, unsigned; must satisfy 10**MAX_DIGITS-1 < 2**WIDTH
//   MAX_DIGITS  4   max decimal digits per operand; further digits are ignored
// PORTS
//   clock      in   1      single clock, all state on posedge
//   reset      in   1      synchronous, active-high; clears all state
//   key        in   5      {valid,code} from scanner; code = col*4+row
//   req_valid  out  1      request to ALU: op_a, op_b, op_code are valid
//   req_ready  in   1      ALU accepts the request when req_valid & req_ready
//   op_a       out  WIDTH  first operand
//   op_b       out  WIDTH  second operand
//   op_code    out  2      0:+ 1:- 2:* 3:/
//   res_valid  in   1      one-cycle strobe: result is valid
//   result     in   WIDTH  ALU result
//   display    out  WIDTH  value to show
//   busy       out  1      high in S_REQ and S_WAIT
// BEHAVIOUR
//   Reset: state=S_A; acc_a, acc_b, digit counters, op_code, req_valid, display, busy and
//     key_prev all 0. Reset in any state, including S_REQ/S_WAIT, drops the request.
//   Press event: ev = key[4] & (key != key_prev); key_prev <= key every cycle. A held key
//     gives exactly one event. A repeat of the same key needs an intervening non-valid value.
//   Decode table, code -> key:
//     0:'1' 1:'4' 2:'7' 3:'0' 4:'2' 5:'5' 6:'8' 7:F 8:'3' 9:'6' 10:'9' 11:E
//     12:A(+) 13:B(-) 14:C(*) 15:D(/)
//   Timing: an event at edge N updates state and accumulators at edge N. No extra latency.
//   Digit d: if cnt < MAX_DIGITS then acc <= acc*10+d and cnt++; otherwise ignored.
//     Leading zeros count as digits.
//   States:
//     S_A: digit -> acc_a. A-D -> op_code, acc_b=0, cnt_b=0, go S_B (acc_a may be 0).
//       E -> ignored.
//     S_B: digit -> acc_b. A-D -> replaces op_code if cnt_b==0, otherwise ignored.
//       E -> op_a=acc_a, op_b=acc_b (0 if no digits), req_valid=1, go S_REQ.
//     S_REQ: req_valid, op_a, op_b and op_code stay stable until req_ready.
//       On the handshake edge: req_valid<=0, go S_WAIT. All keys are ignored, including F.
//     S_WAIT: res_valid -> acc_a<=result, cnt_a=MAX_DIGITS (no appending), go S_DONE.
//       Keys are ignored.
//     S_DONE: digit -> acc_a=d, cnt_a=1, go S_A. A-D -> chains with acc_a=result, go S_B.
//       E -> ignored.
//   F (clear) in S_A, S_B or S_DONE: acc_a, acc_b, counters and op_code are zeroed, go S_A.
//   res_valid outside S_WAIT is ignored. req_ready outside S_REQ is ignored.
//   display: S_A -> acc_a. S_B -> (cnt_b ? acc_b : acc_a). S_REQ/S_WAIT -> acc_b.
//     S_DONE -> acc_a.
//   busy = (state==S_REQ)|(state==S_WAIT). No arithmetic wrap is possible under the
//     parameter constraint.
// TESTING
//   T1: codes 0,4,12,8,11 ('1','2',+,'3',E), req_ready=1
//     -> req_valid for 1 cycle, op_a=12, op_b=3, op_code=0.
//   T2: key=5'b10000 held 10 cycles, then 0, then 5'b10000 again
//     -> acc_a=11 (two events only).
//   T3: digits 1,2,3,4,5 -> display=1234; the fifth digit is ignored.
//   T4: 7,+,-,4,E with req_ready low 5 cycles
//     -> op_code=1, req_valid and operands stable 5 cycles; deassert after ready;
//     res_valid with result=3 -> display=3; then C,2,E -> op_a=3, op_b=2, op_code=2.
//   T5: 9,F -> display=0, state S_A. F pressed in S_REQ -> request still held.
//   T6: reset asserted in S_WAIT, then res_valid=1 result=77
//     -> display stays 0, req_valid=0, busy=0.

Source files
------------

// File: rtl/calc_key_entry.sv
// Keypad entry controller: builds two decimal operands and an operator from
// scanner key presses, hands them to the ALU over valid/ready, latches the result.
module calc_key_entry #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned MAX_DIGITS = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       key,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [1:0]       op_code,
  input  logic             res_valid,
  input  logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] display,
  output logic             busy
);

  localparam int unsigned CW = $clog2(MAX_DIGITS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DIGITS);

  typedef enum logic [2:0] {S_A, S_B, S_REQ, S_WAIT, S_DONE} state_t;

  state_t           state, state_n;
  logic [4:0]       key_prev;
  logic [WIDTH-1:0] acc_a, acc_a_n, acc_b, acc_b_n;
  logic [CW-1:0]    cnt_a, cnt_a_n, cnt_b, cnt_b_n;
  logic [1:0]       op_code_n;
  logic             req_valid_n;
  logic [WIDTH-1:0] op_a_n, op_b_n, display_n;
  logic             busy_n;

  logic       ev, is_digit, is_op, is_e, is_f;
  logic [3:0] digit;

  // Key decode; an event is a valid key that differs from last cycle's value
  always_comb begin
    ev       = key[4] & (key != key_prev);
    is_digit = 1'b1;
    digit    = 4'd0;
    case (key[3:0])
      4'd0:    digit = 4'd1;
      4'd1:    digit = 4'd4;
      4'd2:    digit = 4'd7;
      4'd3:    digit = 4'd0;
      4'd4:    digit = 4'd2;
      4'd5:    digit = 4'd5;
      4'd6:    digit = 4'd8;
      4'd8:    digit = 4'd3;
      4'd9:    digit = 4'd6;
      4'd10:   digit = 4'd9;
      default: is_digit = 1'b0;
    endcase
    is_op = (key[3:2] == 2'b11);
    is_e  = (key[3:0] == 4'd11);
    is_f  = (key[3:0] == 4'd7);
  end

  // Next-state and datapath updates
  always_comb begin
    state_n     = state;
    acc_a_n     = acc_a;
    acc_b_n     = acc_b;
    cnt_a_n     = cnt_a;
    cnt_b_n     = cnt_b;
    op_code_n   = op_code;
    req_valid_n = req_valid;
    op_a_n      = op_a;
    op_b_n      = op_b;
    display_n   = display;
    busy_n      = busy;

    case (state)
      S_A: begin
        if (ev && is_digit) begin
          if (cnt_a < CNT_MAX) begin
            acc_a_n = WIDTH'(acc_a * WIDTH'(10)) + WIDTH'(digit);
            cnt_a_n = cnt_a + CW'(1);
          end
        end else if (ev && is_op) begin
          op_code_n = key[1:0];
          acc_b_n   = '0;
          cnt_b_n   = '0;
          state_n   = S_B;
        end
      end
      S_B: begin
        if (ev && is_digit) begin
          if (cnt_b < CNT_MAX) begin
            acc_b_n = WIDTH'(acc_b * WIDTH'(10)) + WIDTH'(digit);
            cnt_b_n = cnt_b + CW'(1);
          end
        end else if (ev && is_op) begin
          if (cnt_b == '0) op_code_n = key[1:0];
        end else if (ev && is_e) begin
          op_a_n      = acc_a;
          op_b_n      = acc_b;
          req_valid_n = 1'b1;
          state_n     = S_REQ;
        end
      end
      S_REQ: begin
        if (req_ready) begin
          req_valid_n = 1'b0;
          state_n     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (res_valid) begin
          acc_a_n = result;
          cnt_a_n = CNT_MAX;
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        if (ev && is_digit) begin
          acc_a_n = WIDTH'(digit);
          cnt_a_n = CW'(1);
          state_n = S_A;
        end else if (ev && is_op) begin
          op_code_n = key[1:0];
          acc_b_n   = '0;
          cnt_b_n   = '0;
          state_n   = S_B;
        end
      end
      default: state_n = S_A;
    endcase

    // Clear works from any entry state but never aborts an outstanding request
    if (ev && is_f && (state == S_A || state == S_B || state == S_DONE)) begin
      acc_a_n   = '0;
      acc_b_n   = '0;
      cnt_a_n   = '0;
      cnt_b_n   = '0;
      op_code_n = 2'd0;
      state_n   = S_A;
    end

    // Display and busy are registered from next-state values so they track state
    case (state_n)
      S_B:          display_n = (cnt_b_n != '0) ? acc_b_n : acc_a_n;
      S_REQ, S_WAIT: display_n = acc_b_n;
      default:      display_n = acc_a_n;
    endcase
    busy_n = (state_n == S_REQ) || (state_n == S_WAIT);
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_A;
      key_prev  <= 5'd0;
      acc_a     <= '0;
      acc_b     <= '0;
      cnt_a     <= '0;
      cnt_b     <= '0;
      op_code   <= 2'd0;
      req_valid <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      display   <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      key_prev  <= key;
      acc_a     <= acc_a_n;
      acc_b     <= acc_b_n;
      cnt_a     <= cnt_a_n;
      cnt_b     <= cnt_b_n;
      op_code   <= op_code_n;
      req_valid <= req_valid_n;
      op_a      <= op_a_n;
      op_b      <= op_b_n;
      display   <= display_n;
      busy      <= busy_n;
    end
  end

endmodule
